// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiplier read sequencer.
package mvm_pkg;

    // Sequencer states: wait for start, issue reads, let the delay line empty, pulse done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default matrix geometry shared by the datapath blocks.
    localparam int DEF_NUM_ROWS = 8;
    localparam int DEF_VEC_LEN  = 8;

    // Bit width needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_seq_flag_pipe.sv
// Fixed-depth shift register carrying the {valid, first, last} control tags
// alongside the memory read latency. Every stage clears on reset so an
// aborted job leaves no stale valid behind.
module flag_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    // Shift the tags one stage per clock; stage 0 takes the issue-cycle tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '0;
            end
        end else begin
            stage_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/mvm_seq.sv
// Read sequencer for the matrix-vector multiplier: walks the matrix in
// row-major order, issues matrix/vector read addresses and produces the
// valid/first/last stream that lines up with the memory read data.
module mvm_seq
    import mvm_pkg::*;
#(
    parameter  int NUM_ROWS = DEF_NUM_ROWS,
    parameter  int VEC_LEN  = DEF_VEC_LEN,
    parameter  int MEM_LAT  = 1,
    localparam int MAT_AW   = clog2_min1(NUM_ROWS * VEC_LEN),
    localparam int VEC_AW   = clog2_min1(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ostall,
    output logic              rd_en,
    output logic [MAT_AW-1:0] mat_raddr,
    output logic [VEC_AW-1:0] vec_raddr,
    output logic              ovalid,
    output logic              ofirst,
    output logic              olast,
    output logic              busy,
    output logic              done
);

    localparam int ROW_AW = clog2_min1(NUM_ROWS);
    localparam int DRN_W  = clog2_min1(MEM_LAT);

    localparam logic [VEC_AW-1:0] COL_LAST = VEC_AW'(VEC_LEN - 1);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(NUM_ROWS - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(MEM_LAT - 1);

    state_t            state;
    logic [ROW_AW-1:0] row;
    logic [VEC_AW-1:0] col;
    logic [MAT_AW-1:0] mat_addr;
    logic [DRN_W-1:0]  drain_cnt;

    logic issue;
    logic col_last;
    logic row_last;
    logic [2:0] tag_p0;
    logic [2:0] tag_out;

    // An element is issued on every unstalled RUN cycle; the address registers
    // already hold the element, so a stall only has to suppress the enable.
    assign issue    = (state == RUN) && !ostall;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    // Sequencer FSM with row/column counters and a running matrix address
    // (row*VEC_LEN+col advances by one per element, so no multiplier).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            mat_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        row      <= '0;
                        col      <= '0;
                        mat_addr <= '0;
                    end
                end
                RUN: begin
                    if (!ostall) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row       <= '0;
                                mat_addr  <= '0;
                                drain_cnt <= '0;
                                state     <= DRAIN;
                            end else begin
                                row      <= row + 1'b1;
                                mat_addr <= mat_addr + 1'b1;
                            end
                        end else begin
                            col      <= col + 1'b1;
                            mat_addr <= mat_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue stage (p0): tags are qualified by issue so first/last never
    // appear without valid at the far end of the delay line.
    assign tag_p0 = {issue, issue && (col == '0), issue && col_last};

    // Memory latency stages: tags emerge MEM_LAT cycles after their issue.
    flag_pipe #(
        .DEPTH (MEM_LAT),
        .WIDTH (3)
    ) u_flag_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_p0),
        .dout (tag_out)
    );

    assign rd_en     = issue;
    assign mat_raddr = mat_addr;
    assign vec_raddr = col;
    assign ovalid    = tag_out[2];
    assign ofirst    = tag_out[1];
    assign olast     = tag_out[0];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mvm_seq.sv
// Bench for mvm_seq: four instances with different geometry share clock and
// stimulus; one is selected per scenario and compared cycle by cycle against
// an element-level model of the job schedule.
module tb_mvm_seq;

    localparam int N_MAX = 256;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic ostall;

    always #5 clk = ~clk;

    // Instance A: 2x3, latency 1
    logic       a_rd_en, a_ovalid, a_ofirst, a_olast, a_busy, a_done;
    logic [2:0] a_mat;
    logic [1:0] a_vec;
    // Instance B: 1x4, latency 3
    logic       b_rd_en, b_ovalid, b_ofirst, b_olast, b_busy, b_done;
    logic [1:0] b_mat;
    logic [1:0] b_vec;
    // Instance C: 3x1, latency 1
    logic       c_rd_en, c_ovalid, c_ofirst, c_olast, c_busy, c_done;
    logic [1:0] c_mat;
    logic [0:0] c_vec;
    // Instance D: 3x4, latency 2
    logic       d_rd_en, d_ovalid, d_ofirst, d_olast, d_busy, d_done;
    logic [3:0] d_mat;
    logic [1:0] d_vec;

    mvm_seq #(.NUM_ROWS(2), .VEC_LEN(3), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ostall(ostall),
        .rd_en(a_rd_en), .mat_raddr(a_mat), .vec_raddr(a_vec),
        .ovalid(a_ovalid), .ofirst(a_ofirst), .olast(a_olast),
        .busy(a_busy), .done(a_done));

    mvm_seq #(.NUM_ROWS(1), .VEC_LEN(4), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ostall(ostall),
        .rd_en(b_rd_en), .mat_raddr(b_mat), .vec_raddr(b_vec),
        .ovalid(b_ovalid), .ofirst(b_ofirst), .olast(b_olast),
        .busy(b_busy), .done(b_done));

    mvm_seq #(.NUM_ROWS(3), .VEC_LEN(1), .MEM_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .ostall(ostall),
        .rd_en(c_rd_en), .mat_raddr(c_mat), .vec_raddr(c_vec),
        .ovalid(c_ovalid), .ofirst(c_ofirst), .olast(c_olast),
        .busy(c_busy), .done(c_done));

    mvm_seq #(.NUM_ROWS(3), .VEC_LEN(4), .MEM_LAT(2)) dut_d (
        .clk(clk), .rst(rst), .start(start), .ostall(ostall),
        .rd_en(d_rd_en), .mat_raddr(d_mat), .vec_raddr(d_vec),
        .ovalid(d_ovalid), .ofirst(d_ofirst), .olast(d_olast),
        .busy(d_busy), .done(d_done));

    int nr_of [4] = '{2, 1, 3, 3};
    int vl_of [4] = '{3, 4, 1, 4};
    int ml_of [4] = '{1, 3, 1, 2};

    // Observation word: [21]=rd_en [20:13]=mat [12:5]=vec [4]=ovalid [3]=ofirst [2]=olast [1]=busy [0]=done
    function automatic logic [21:0] pack(input logic rd, input logic [7:0] mat, input logic [7:0] vec,
                                         input logic ov, input logic of, input logic ol,
                                         input logic bz, input logic dn);
        return {rd, mat, vec, ov, of, ol, bz, dn};
    endfunction

    int          sel;
    logic [21:0] obs;

    always_comb begin
        obs = '0;
        case (sel)
            0: obs = pack(a_rd_en, 8'(a_mat), 8'(a_vec), a_ovalid, a_ofirst, a_olast, a_busy, a_done);
            1: obs = pack(b_rd_en, 8'(b_mat), 8'(b_vec), b_ovalid, b_ofirst, b_olast, b_busy, b_done);
            2: obs = pack(c_rd_en, 8'(c_mat), 8'(c_vec), c_ovalid, c_ofirst, c_olast, c_busy, c_done);
            3: obs = pack(d_rd_en, 8'(d_mat), 8'(d_vec), d_ovalid, d_ofirst, d_olast, d_busy, d_done);
            default: obs = '0;
        endcase
    end

    bit          start_v [N_MAX];
    bit          stall_v [N_MAX];
    bit          rst_v   [N_MAX];
    logic [21:0] exp_t   [N_MAX];
    logic [21:0] got_t   [N_MAX];
    logic [21:0] got_raw [N_MAX];

    int errors = 0;
    int checks = 0;

    task automatic clear_stim();
        for (int i = 0; i < N_MAX; i++) begin
            start_v[i] = 1'b0;
            stall_v[i] = 1'b0;
            rst_v[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        ostall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive cycle c's inputs just after the edge that opens it, sample at mid-cycle.
    // Addresses are only meaningful while rd_en is high, so they are masked otherwise.
    task automatic run_trace(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst    = rst_v[c];
            start  = start_v[c];
            ostall = stall_v[c];
            @(negedge clk);
            got_raw[c] = obs;
            got_t[c]   = obs;
            if (!obs[21]) got_t[c][20:5] = '0;
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        start  = 1'b0;
        ostall = 1'b0;
    endtask

    // Element-level schedule: a job begins when start is seen while idle; element k
    // (row k/VL, col k%VL, matrix address k) goes out on the k-th unstalled cycle
    // after that, its data is valid ML cycles later, done follows the final data
    // by one cycle and the block is idle again the cycle after done.
    task automatic build_model(input int s, input int n);
        int nr, vl, ml, total, t, k, last_t, idle_from;
        nr = nr_of[s];
        vl = vl_of[s];
        ml = ml_of[s];
        total = nr * vl;
        for (int i = 0; i < N_MAX; i++) exp_t[i] = '0;
        idle_from = 0;
        for (int c = 0; c < n; c++) begin
            if (c >= idle_from && start_v[c]) begin
                k = 0;
                t = c + 1;
                last_t = c;
                while (k < total && t < n) begin
                    exp_t[t][1] = 1'b1;
                    if (!stall_v[t]) begin
                        exp_t[t][21]    = 1'b1;
                        exp_t[t][20:13] = 8'(k);
                        exp_t[t][12:5]  = 8'(k % vl);
                        if (t + ml < n) begin
                            exp_t[t+ml][4] = 1'b1;
                            exp_t[t+ml][3] = ((k % vl) == 0);
                            exp_t[t+ml][2] = ((k % vl) == vl - 1);
                        end
                        k++;
                        last_t = t;
                    end
                    t++;
                end
                if (k == total) begin
                    for (int d = last_t + 1; d <= last_t + ml + 1 && d < n; d++) exp_t[d][1] = 1'b1;
                    if (last_t + ml + 1 < n) exp_t[last_t+ml+1][0] = 1'b1;
                    idle_from = last_t + ml + 2;
                end else begin
                    idle_from = n;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs !== 22'h0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=%h", s, obs, 22'h0);
            end
        end
    endtask

    task automatic test_basic();
        int n, cnt_ov, done_at;
        n = 14;
        sel = 0;
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        run_trace(n);
        build_model(0, n);
        cnt_ov = 0;
        done_at = -1;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
            if (got_t[c][4]) cnt_ov++;
            if (got_t[c][0] && done_at < 0) done_at = c;
        end
        checks++;
        if (cnt_ov !== 6) begin errors++; $display("FAIL basic_ovalid_count got=%0d exp=6", cnt_ov); end
        checks++;
        if (done_at !== 8) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=8", done_at); end
        checks++;
        if (got_t[7][2] !== 1'b1) begin errors++; $display("FAIL basic_olast_c7 got=%b exp=1", got_t[7][2]); end
    endtask

    task automatic test_stall();
        int n, cnt_ov, done_at;
        n = 16;
        sel = 0;
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        stall_v[3] = 1'b1;
        stall_v[4] = 1'b1;
        run_trace(n);
        build_model(0, n);
        cnt_ov = 0;
        done_at = -1;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
            if (got_t[c][4]) cnt_ov++;
            if (got_t[c][0] && done_at < 0) done_at = c;
        end
        checks++;
        if (cnt_ov !== 6) begin errors++; $display("FAIL stall_ovalid_count got=%0d exp=6", cnt_ov); end
        checks++;
        if (done_at !== 10) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=10", done_at); end
        checks++;
        if (got_t[5][21:13] !== 9'h102) begin
            errors++;
            $display("FAIL stall_addr2_c5 got=%h exp=%h", got_t[5][21:13], 9'h102);
        end
    endtask

    task automatic test_latency();
        int n, cnt_ov, done_at, first_ov;
        n = 14;
        sel = 1;
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        run_trace(n);
        build_model(1, n);
        cnt_ov = 0;
        done_at = -1;
        first_ov = -1;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL latency cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
            if (got_t[c][4]) cnt_ov++;
            if (got_t[c][4] && first_ov < 0) first_ov = c;
            if (got_t[c][0] && done_at < 0) done_at = c;
        end
        checks++;
        if (cnt_ov !== 4) begin errors++; $display("FAIL latency_ovalid_count got=%0d exp=4", cnt_ov); end
        checks++;
        if (first_ov !== 4) begin errors++; $display("FAIL latency_first_ovalid got=%0d exp=4", first_ov); end
        checks++;
        if (done_at !== 8) begin errors++; $display("FAIL latency_done_cycle got=%0d exp=8", done_at); end
    endtask

    task automatic test_veclen1();
        int n, cnt_ov, cnt_f, cnt_l;
        n = 12;
        sel = 2;
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        run_trace(n);
        build_model(2, n);
        cnt_ov = 0;
        cnt_f = 0;
        cnt_l = 0;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL veclen1 cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
            if (got_t[c][4]) cnt_ov++;
            if (got_t[c][4] && got_t[c][3]) cnt_f++;
            if (got_t[c][4] && got_t[c][2]) cnt_l++;
        end
        checks++;
        if (cnt_ov !== 3) begin errors++; $display("FAIL veclen1_ovalid_count got=%0d exp=3", cnt_ov); end
        checks++;
        if (cnt_f !== 3 || cnt_l !== 3) begin
            errors++;
            $display("FAIL veclen1_first_last got=%0d/%0d exp=3/3", cnt_f, cnt_l);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        int n;
        n = 16;
        sel = 0;
        do_reset();
        clear_stim();
        start_v[0] = 1'b1;
        start_v[3] = 1'b1;
        rst_v[4]   = 1'b1;
        run_trace(n);
        build_model(0, n);
        for (int c = 5; c < n; c++) exp_t[c] = '0;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
        end
        checks++;
        if (got_raw[5] !== 22'h0) begin
            errors++;
            $display("FAIL abort_all_zero_c5 got=%h exp=%h", got_raw[5], 22'h0);
        end
    endtask

    task automatic test_back_to_back();
        int n, cnt_done;
        n = 40;
        sel = 0;
        do_reset();
        clear_stim();
        for (int c = 0; c < n; c++) start_v[c] = 1'b1;
        run_trace(n);
        build_model(0, n);
        cnt_done = 0;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (got_t[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, got_t[c], exp_t[c]);
            end
            if (got_t[c][0]) cnt_done++;
        end
        checks++;
        if (cnt_done !== 4) begin errors++; $display("FAIL b2b_done_count got=%0d exp=4", cnt_done); end
        checks++;
        if (got_t[10][21:13] !== 9'h100) begin
            errors++;
            $display("FAIL b2b_restart_addr_c10 got=%h exp=%h", got_t[10][21:13], 9'h100);
        end
    endtask

    task automatic test_random();
        int n;
        n = 120;
        for (int it = 0; it < 6; it++) begin
            sel = (it % 2 == 0) ? 3 : 0;
            do_reset();
            clear_stim();
            start_v[0] = 1'b1;
            for (int c = 1; c < n; c++) begin
                start_v[c] = ($urandom_range(2, 0) == 0);
                stall_v[c] = ($urandom_range(2, 0) == 0);
            end
            run_trace(n);
            build_model(sel, n);
            for (int c = 0; c < n; c++) begin
                checks++;
                if (got_t[c] !== exp_t[c]) begin
                    errors++;
                    $display("FAIL random it=%0d inst=%0d cyc=%0d got=%h exp=%h", it, sel, c, got_t[c], exp_t[c]);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ostall = 1'b0;
        sel    = 0;
        test_reset();
        test_basic();
        test_stall();
        test_latency();
        test_veclen1();
        test_start_ignored_and_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mvm_seq.md
Name: mvm_seq

Overview:
- Read-sequencer and control-flag generator feeding the accumulator stage of the matrix-vector multiplier.
- On `start`, walks a NUM_ROWS x VEC_LEN matrix in row-major order.
  - Issues matrix and vector memory read addresses.
  - Emits a valid/first/last control stream aligned to memory read latency; this stream drives the multiplier/accumulator `ivalid`/`first`/`last` inputs.
- Supports downstream stall and signals completion with a one-cycle done pulse.

Parameters:
- NUM_ROWS, 8, matrix rows (= number of accumulator results per job); >= 1.
- VEC_LEN, 8, elements per row / vector length; >= 1.
- MEM_LAT, 1, read latency of matrix/vector memories in cycles, address cycle to data cycle; >= 1.
- MAT_AW, $clog2(NUM_ROWS*VEC_LEN) (min 1), matrix address width (derived, localparam).
- VEC_AW, $clog2(VEC_LEN) (min 1), vector address width (derived, localparam).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, begin job; sampled only in IDLE.
- ostall, in, 1, downstream backpressure; holds issue while high.
- rd_en, out, 1, memory read enable (registered).
- mat_raddr, out, MAT_AW, matrix read address = row*VEC_LEN+col (registered).
- vec_raddr, out, VEC_AW, vector read address = col (registered).
- ovalid, out, 1, data on memory outputs valid this cycle.
- ofirst, out, 1, qualifies ovalid: first element of a row.
- olast, out, 1, qualifies ovalid: last element of a row.
- busy, out, 1, state != IDLE.
- done, out, 1, one-cycle pulse at job end.

Behaviour:
- Reset values: all outputs 0, state IDLE, row/col counters 0, all delay-line stages cleared.
- Reset mid-job aborts immediately: no further ovalid and no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN; row=col=0.
  - RUN, ostall=0 (issue cycle):
    - rd_en=1, mat_raddr=row*VEC_LEN+col, vec_raddr=col.
    - Tag first=(col==0), last=(col==VEC_LEN-1).
    - col increments; on wrap col->0 and row++.
    - Issuing element (NUM_ROWS-1, VEC_LEN-1) -> DRAIN.
  - RUN, ostall=1: rd_en=0, counters and addresses hold. Stall must not drop or duplicate elements.
  - DRAIN: lasts exactly MEM_LAT cycles (drain counter) so the final element exits the delay line -> DONE. ostall is ignored.
  - DONE: done=1 for one cycle -> IDLE.
- Issue timing:
  - Addresses and rd_en are registered: the first address appears the cycle after start is sampled.
  - rd_en, first and last pass through a MEM_LAT-stage delay line. ovalid/ofirst/olast are high exactly MEM_LAT cycles after the matching rd_en cycle.
  - ofirst and olast are 0 whenever ovalid=0.
- VEC_LEN=1: every element has ofirst=olast=1.
- Per job: exactly NUM_ROWS*VEC_LEN ovalid cycles, NUM_ROWS ofirst pulses and NUM_ROWS olast pulses.
- Throughput: one element per cycle when unstalled.
- start while busy is ignored; there is no queuing.
- Counters: col width VEC_AW, row width $clog2(NUM_ROWS) (min 1). mat_raddr is computed by a running address counter, not a multiplier.

Decomposition:
- Package mvm_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE).
  - width helper function clog2_min1.
  - shared default constants NUM_ROWS/VEC_LEN.
- Sub-module flag_pipe (parameters DEPTH, WIDTH): shift register with synchronous reset, carrying {valid, first, last}.

Test Plan:
- NUM_ROWS=2, VEC_LEN=3, MEM_LAT=1. start high in cycle 0:
  - rd_en high cycles 1-6, mat_raddr 0,1,2,3,4,5, vec_raddr 0,1,2,0,1,2.
  - ovalid high cycles 2-7; ofirst in cycles 2 and 5; olast in cycles 4 and 7.
  - DRAIN in cycle 7, done in cycle 8 only; busy high cycles 1-8.
- Same config, ostall high in cycles 3-4: addresses 0,1 issued in cycles 1-2, address 2 in cycle 5, remaining addresses in cycles 6-8. ovalid has a gap in cycles 4-5; done in cycle 10; 6 total ovalid cycles.
- MEM_LAT=3, NUM_ROWS=1, VEC_LEN=4: ovalid cycles 4-7 for issues in cycles 1-4; DRAIN cycles 5-7; done in cycle 8.
- VEC_LEN=1, NUM_ROWS=3: 3 ovalid cycles, each with ofirst=olast=1.
- start pulsed again in cycle 3 of a job: ignored. rst asserted in cycle 4 of a job: next cycle all outputs 0 and busy 0; no done; no further ovalid.
- Back-to-back jobs: start held high continuously. A second job begins the cycle after IDLE is re-entered, and its addresses restart at 0.
